// File: rtl/stack_memory.sv
// LIFO operand stack for the RPN calculator datapath with a zero-latency top-of-stack read.
// Optional macro STACK_PEEK2_EN adds a second-from-top read port (memOut2) and twoValid.
module stack_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] memIn,
  input  logic             clrErr,
  output logic [WIDTH-1:0] memOut,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
`ifdef STACK_PEEK2_EN
  ,
  output logic [WIDTH-1:0] memOut2,
  output logic             twoValid
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_next;
  logic [PTR_W-1:0] sp_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             ovf_evt;
  logic             unf_evt;

  assign sp_m1   = sp - PTR_W'(1);
  assign top_idx = sp_m1[AW-1:0];
  assign empty   = (sp == '0);
  assign full    = (sp == DEPTH_P);
  assign count   = sp;

  // Operation decode from {push,pop}; push+pop rewrites the top in place
  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[AW-1:0];
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp + PTR_W'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          unf_evt = 1'b1;
        end else begin
          sp_next = sp_m1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          sp_next = PTR_W'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: begin
      end
    endcase
  end

  // Error events win over a simultaneous clear so no event is ever lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      overflow  <= ovf_evt | (overflow & ~clrErr);
      underflow <= unf_evt | (underflow & ~clrErr);
    end
  end

  // Storage is not reset; a write during reset lands above sp and is never visible
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= memIn;
    end
  end

  assign memOut = empty ? '0 : mem[top_idx];

`ifdef STACK_PEEK2_EN
  logic [PTR_W-1:0] sp_m2;

  assign sp_m2    = sp - PTR_W'(2);
  assign twoValid = (sp >= PTR_W'(2));
  assign memOut2  = twoValid ? mem[sp_m2[AW-1:0]] : '0;
`endif

endmodule

// File: tb/tb_stack_memory.sv
// Self-checking bench for stack_memory (DEPTH=4): table-driven vectors with a scoreboard queue,
// plus hand-written sequences for power-up reset and asynchronous reset mid-push.
module tb_stack_memory;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 3;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] memIn;
  logic             clrErr;
  logic [WIDTH-1:0] memOut;
  logic [PTR_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef STACK_PEEK2_EN
  logic [WIDTH-1:0] memOut2;
  logic             twoValid;
`endif

  int errors = 0;
  int checks = 0;

  stack_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .memIn    (memIn),
    .clrErr   (clrErr),
    .memOut   (memOut),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
`ifdef STACK_PEEK2_EN
    ,
    .memOut2  (memOut2),
    .twoValid (twoValid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        push;
    logic        pop;
    logic        clr;
    logic [31:0] din;
    logic [2:0]  cnt;
    logic [31:0] top;
    logic        ovf;
    logic        unf;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  cnt;
    logic [31:0] top;
    logic        ovf;
    logic        unf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic p, input logic q, input logic c,
                        input logic [31:0] d, input logic [2:0] n, input logic [31:0] t,
                        input logic o, input logic u);
    vec_t v;
    v.name = name; v.push = p; v.pop = q; v.clr = c; v.din = d;
    v.cnt = n; v.top = t; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got no expected entry, expected one queued");
    end else begin
      e = sb.pop_front();
      compare({e.name, ".count"}, 32'(count), 32'(e.cnt));
      compare({e.name, ".memOut"}, memOut, e.top);
      compare({e.name, ".empty"}, 32'(empty), 32'(e.cnt == 3'd0));
      compare({e.name, ".full"}, 32'(full), 32'(e.cnt == 3'(DEPTH)));
      compare({e.name, ".overflow"}, 32'(overflow), 32'(e.ovf));
      compare({e.name, ".underflow"}, 32'(underflow), 32'(e.unf));
    end
  endtask

  // Drive one operation for one edge, queue its expectation, then check after the edge
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    push   = v.push;
    pop    = v.pop;
    clrErr = v.clr;
    memIn  = v.din;
    e.name = v.name; e.cnt = v.cnt; e.top = v.top; e.ovf = v.ovf; e.unf = v.unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    push   = 1'b0;
    pop    = 1'b0;
    clrErr = 1'b0;
    memIn  = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    //      name          push pop clr din    cnt top    ovf unf
    addVec("idle0",       0, 0, 0, 32'h0,  0, 32'h0,  0, 0);
    addVec("push5",       1, 0, 0, 32'h5,  1, 32'h5,  0, 0);
    addVec("push3",       1, 0, 0, 32'h3,  2, 32'h3,  0, 0);
    addVec("pop3",        0, 1, 0, 32'h0,  1, 32'h5,  0, 0);
    addVec("pop5",        0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
    addVec("push11",      1, 0, 0, 32'h11, 1, 32'h11, 0, 0);
    addVec("push22",      1, 0, 0, 32'h22, 2, 32'h22, 0, 0);
    addVec("push33",      1, 0, 0, 32'h33, 3, 32'h33, 0, 0);
    addVec("push44",      1, 0, 0, 32'h44, 4, 32'h44, 0, 0);
    addVec("push55full",  1, 0, 0, 32'h55, 4, 32'h44, 1, 0);
    addVec("ovfsticky",   0, 0, 0, 32'h0,  4, 32'h44, 1, 0);
    addVec("clrovf",      0, 0, 1, 32'h0,  4, 32'h44, 0, 0);
    addVec("ovfvsclr",    1, 0, 1, 32'h66, 4, 32'h44, 1, 0);
    addVec("clrovf2",     0, 0, 1, 32'h0,  4, 32'h44, 0, 0);
    addVec("replfull",    1, 1, 0, 32'h99, 4, 32'h99, 0, 0);
    addVec("popto3",      0, 1, 0, 32'h0,  3, 32'h33, 0, 0);
    addVec("popto2",      0, 1, 0, 32'h0,  2, 32'h22, 0, 0);
    addVec("popto1",      0, 1, 0, 32'h0,  1, 32'h11, 0, 0);
    addVec("popto0",      0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
    addVec("popempty",    0, 1, 0, 32'h0,  0, 32'h0,  0, 1);
    addVec("push7",       1, 0, 0, 32'h7,  1, 32'h7,  0, 1);
    addVec("pop7",        0, 1, 0, 32'h0,  0, 32'h0,  0, 1);
    addVec("replempty",   1, 1, 0, 32'hA,  1, 32'hA,  0, 1);
    addVec("popA",        0, 1, 0, 32'h0,  0, 32'h0,  0, 1);
    addVec("push5b",      1, 0, 0, 32'h5,  1, 32'h5,  0, 1);
    addVec("push3b",      1, 0, 0, 32'h3,  2, 32'h3,  0, 1);
    addVec("repl8",       1, 1, 0, 32'h8,  2, 32'h8,  0, 1);
    addVec("pop8",        0, 1, 0, 32'h0,  1, 32'h5,  0, 1);
    addVec("clrunf",      0, 0, 1, 32'h0,  1, 32'h5,  0, 0);
    addVec("pop5b",       0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
    addVec("unfvsclr",    0, 1, 1, 32'h0,  0, 32'h0,  0, 1);
    addVec("clrunf2",     0, 0, 1, 32'h0,  0, 32'h0,  0, 0);
    addVec("push1",       1, 0, 0, 32'h1,  1, 32'h1,  0, 0);
    addVec("push2",       1, 0, 0, 32'h2,  2, 32'h2,  0, 0);
    addVec("push3c",      1, 0, 0, 32'h3,  3, 32'h3,  0, 0);

    idleInputs();
    rst = 1'b1;
    #3;
    compare("rst.count", 32'(count), 32'd0);
    compare("rst.empty", 32'(empty), 32'd1);
    compare("rst.full", 32'(full), 32'd0);
    compare("rst.memOut", memOut, 32'h0);
    compare("rst.overflow", 32'(overflow), 32'd0);
    compare("rst.underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Asynchronous reset arrives while a push of 0x9 is set up on a 3-entry stack
    @(negedge clk);
    push  = 1'b1;
    memIn = 32'h9;
    #2;
    rst = 1'b1;
    #1;
    compare("arst.count", 32'(count), 32'd0);
    compare("arst.empty", 32'(empty), 32'd1);
    compare("arst.memOut", memOut, 32'h0);
    @(posedge clk);
    #1;
    compare("arst.hold.count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    @(posedge clk);
    #1;
    compare("arst.rel.count", 32'(count), 32'd0);
    compare("arst.rel.empty", 32'(empty), 32'd1);
    compare("arst.rel.memOut", memOut, 32'h0);

    v.name = "post5"; v.push = 1; v.pop = 0; v.clr = 0; v.din = 32'h5;
    v.cnt = 1; v.top = 32'h5; v.ovf = 0; v.unf = 0;
    applyStimulus(v);
`ifdef STACK_PEEK2_EN
    compare("peek.twoValid1", 32'(twoValid), 32'd0);
    compare("peek.memOut2_1", memOut2, 32'h0);
`endif
    v.name = "post3"; v.din = 32'h3; v.cnt = 2; v.top = 32'h3;
    applyStimulus(v);
`ifdef STACK_PEEK2_EN
    compare("peek.twoValid2", 32'(twoValid), 32'd1);
    compare("peek.memOut2_2", memOut2, 32'h5);
`endif

    @(negedge clk);
    idleInputs();
    compare("scoreboard.drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
